// File: rtl/ma_clk_cfg_pkg.sv
// Shared definitions for the clock-group configuration block: domain indices,
// register map offsets, field bit positions and sequencer states.
package ma_clk_cfg_pkg;

  localparam int N_DOM = 5;

  typedef enum logic [2:0] {
    DOM_CPU = 3'd0,
    DOM_AXI = 3'd1,
    DOM_APB = 3'd2,
    DOM_I2C = 3'd3,
    DOM_IMP = 3'd4
  } dom_e;

  // Byte offset of STATUS; CFG_d lives at 4*d below it.
  localparam logic [4:0] OFF_STATUS = 5'h14;

  // CFG_d field positions (divider occupies [DIV_DW-1:0]).
  localparam int TOG_BIT  = 8;
  localparam int CKEN_BIT = 9;
  localparam int ICG_BIT  = 10;

  // STATUS field positions.
  localparam int ST_BUSY_BIT = 0;
  localparam int ST_PEND_LSB = 1;
  localparam int ST_ACT_LSB  = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATE   = 3'd1,
    ST_WAIT_G = 3'd2,
    ST_APPLY  = 3'd3,
    ST_WAIT_S = 3'd4,
    ST_UNGATE = 3'd5
  } state_e;

  // Index of the lowest set bit; lower index means higher service priority.
  function automatic dom_e lowest_set(input logic [N_DOM-1:0] v);
    dom_e idx;
    idx = DOM_CPU;
    for (int i = N_DOM - 1; i >= 0; i--) begin
      if (v[i]) idx = dom_e'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ma_clk_cfg_regfile.sv
// APB register decode, per-domain shadow registers, pending-change bits and
// the read mux.
// Handshake: zero-wait APB-lite; an access is psel&penable, the write commits
// on the clock edge that ends the access cycle, and read data / slave error
// are a combinational function of registers during that same cycle.
module ma_clk_cfg_regfile
  import ma_clk_cfg_pkg::*;
#(
  parameter int DIV_DW  = 4,
  parameter int RST_DIV = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [4:0]                paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic [N_DOM*DIV_DW-1:0]   live_div_i,
  input  logic [N_DOM-1:0]          live_tog_i,
  input  logic [N_DOM-1:0]          live_cken_i,
  input  logic                      busy_i,
  input  dom_e                      active_i,
  input  logic [N_DOM-1:0]          clr_i,
  output logic [31:0]               prdata_o,
  output logic                      pslverr_o,
  output logic [N_DOM*DIV_DW-1:0]   shd_div_o,
  output logic [N_DOM-1:0]          shd_tog_o,
  output logic [N_DOM-1:0]          shd_cken_o,
  output logic [N_DOM-1:0]          shd_icg_o,
  output logic [N_DOM-1:0]          pending_o,
  output logic [N_DOM-1:0]          pend_nxt_o
);

  localparam logic [2:0] IDX_STATUS = OFF_STATUS[4:2];

  logic [N_DOM*DIV_DW-1:0] shd_div_q;
  logic [N_DOM-1:0]        shd_tog_q, shd_cken_q, shd_icg_q, pending_q;
  logic [N_DOM-1:0]        set_pend;
  logic                    acc, wr_cfg, is_cfg, is_status, bad_addr;
  logic [2:0]              idx;
  logic [DIV_DW-1:0]       w_div;
  logic                    w_tog, w_cken, w_icg;
  logic                    unused_bits;

  assign acc       = psel_i & penable_i;
  assign idx       = paddr_i[4:2];
  assign is_cfg    = (idx < IDX_STATUS);
  assign is_status = (idx == IDX_STATUS);
  assign bad_addr  = (idx > IDX_STATUS);
  assign wr_cfg    = acc & pwrite_i & is_cfg;

  assign w_div  = pwdata_i[DIV_DW-1:0];
  assign w_tog  = pwdata_i[TOG_BIT];
  assign w_cken = pwdata_i[CKEN_BIT];
  assign w_icg  = pwdata_i[ICG_BIT];

  assign unused_bits = ^{paddr_i[1:0], pwdata_i};

  // A divider/toggle/enable change needs a sequence if it differs from the live
  // value, or from the shadow (catches a revert while a snapshot is in flight).
  always_comb begin
    set_pend = '0;
    for (int d = 0; d < N_DOM; d++) begin
      if (wr_cfg && (idx == 3'(d))) begin
        if (({w_div, w_tog, w_cken} !=
             {live_div_i[d*DIV_DW +: DIV_DW], live_tog_i[d], live_cken_i[d]}) ||
            ({w_div, w_tog, w_cken} !=
             {shd_div_q[d*DIV_DW +: DIV_DW], shd_tog_q[d], shd_cken_q[d]})) begin
          set_pend[d] = 1'b1;
        end
      end
    end
  end

  // A new request wins over the sequencer's clear of the same domain.
  assign pend_nxt_o = (pending_q & ~clr_i) | set_pend;

  // Shadow registers and pending bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shd_div_q  <= {N_DOM{DIV_DW'(RST_DIV)}};
      shd_tog_q  <= '0;
      shd_cken_q <= '1;
      shd_icg_q  <= '1;
      pending_q  <= '0;
    end else begin
      pending_q <= pend_nxt_o;
      for (int d = 0; d < N_DOM; d++) begin
        if (wr_cfg && (idx == 3'(d))) begin
          shd_div_q[d*DIV_DW +: DIV_DW] <= w_div;
          shd_tog_q[d]  <= w_tog;
          shd_cken_q[d] <= w_cken;
          shd_icg_q[d]  <= w_icg;
        end
      end
    end
  end

  // Read mux; zero outside an access and for unmapped addresses.
  always_comb begin
    prdata_o  = '0;
    pslverr_o = acc & bad_addr;
    if (acc) begin
      if (is_status) begin
        prdata_o[ST_BUSY_BIT]          = busy_i;
        prdata_o[ST_PEND_LSB +: N_DOM] = pending_q;
        prdata_o[ST_ACT_LSB +: 3]      = active_i;
      end else begin
        for (int d = 0; d < N_DOM; d++) begin
          if (is_cfg && (idx == 3'(d))) begin
            prdata_o[DIV_DW-1:0] = shd_div_q[d*DIV_DW +: DIV_DW];
            prdata_o[TOG_BIT]    = shd_tog_q[d];
            prdata_o[CKEN_BIT]   = shd_cken_q[d];
            prdata_o[ICG_BIT]    = shd_icg_q[d];
          end
        end
      end
    end
  end

  assign shd_div_o  = shd_div_q;
  assign shd_tog_o  = shd_tog_q;
  assign shd_cken_o = shd_cken_q;
  assign shd_icg_o  = shd_icg_q;
  assign pending_o  = pending_q;

endmodule

// File: rtl/ma_clk_cfg_seq.sv
// Clock-group configuration block: owns the glitch-safe change sequencer
// (gate ICG, wait, apply divider, settle, restore ICG) and the live outputs.
module ma_clk_cfg_seq
  import ma_clk_cfg_pkg::*;
#(
  parameter int DIV_DW     = 4,
  parameter int GATE_CYC   = 32,
  parameter int SETTLE_CYC = 32,
  parameter int RST_DIV    = 1
) (
  input  logic                    src_clk,
  input  logic                    src_rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [4:0]              paddr,
  input  logic [31:0]             pwdata,
  output logic [31:0]             prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [N_DOM*DIV_DW-1:0] reg_clk_div,
  output logic [N_DOM-1:0]        reg_clk_tog,
  output logic [N_DOM-1:0]        reg_clk_cken,
  output logic [N_DOM-1:0]        reg_icg_on,
  output logic                    busy,
  output logic [2:0]              dbg_state
);

  localparam int CNT_MAX = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e                  state_q;
  dom_e                    active_q, pick;
  logic [CNT_W-1:0]        cnt_q;
  logic [DIV_DW-1:0]       snap_div_q;
  logic                    snap_tog_q, snap_cken_q;
  logic [N_DOM*DIV_DW-1:0] div_q;
  logic [N_DOM-1:0]        tog_q, cken_q, icg_q;
  logic                    busy_q;

  logic [N_DOM*DIV_DW-1:0] shd_div;
  logic [N_DOM-1:0]        shd_tog, shd_cken, shd_icg, pending, pend_nxt, clr_pend;

  ma_clk_cfg_regfile #(
    .DIV_DW  (DIV_DW),
    .RST_DIV (RST_DIV)
  ) u_regfile (
    .clk_i       (src_clk),
    .rst_i       (src_rst),
    .psel_i      (psel),
    .penable_i   (penable),
    .pwrite_i    (pwrite),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
    .live_div_i  (div_q),
    .live_tog_i  (tog_q),
    .live_cken_i (cken_q),
    .busy_i      (busy_q),
    .active_i    (active_q),
    .clr_i       (clr_pend),
    .prdata_o    (prdata),
    .pslverr_o   (pslverr),
    .shd_div_o   (shd_div),
    .shd_tog_o   (shd_tog),
    .shd_cken_o  (shd_cken),
    .shd_icg_o   (shd_icg),
    .pending_o   (pending),
    .pend_nxt_o  (pend_nxt)
  );

  assign pick     = lowest_set(pending);
  assign clr_pend = ((state_q == ST_IDLE) && (|pending)) ? (N_DOM'(1) << pick) : '0;

  // Sequencer FSM plus live divider/toggle/enable/ICG outputs and busy flag.
  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      state_q     <= ST_IDLE;
      active_q    <= DOM_CPU;
      cnt_q       <= '0;
      snap_div_q  <= DIV_DW'(RST_DIV);
      snap_tog_q  <= 1'b0;
      snap_cken_q <= 1'b1;
      div_q       <= {N_DOM{DIV_DW'(RST_DIV)}};
      tog_q       <= '0;
      cken_q      <= '1;
      icg_q       <= '1;
      busy_q      <= 1'b0;
    end else begin
      // Domains outside an active sequence follow their shadow ICG next cycle.
      for (int d = 0; d < N_DOM; d++) begin
        if ((state_q == ST_IDLE) || (active_q != dom_e'(d))) icg_q[d] <= shd_icg[d];
      end
      case (state_q)
        ST_IDLE: begin
          if (|pending) begin
            active_q    <= pick;
            snap_div_q  <= shd_div[int'(pick)*DIV_DW +: DIV_DW];
            snap_tog_q  <= shd_tog[pick];
            snap_cken_q <= shd_cken[pick];
            state_q     <= ST_GATE;
            busy_q      <= 1'b1;
          end else begin
            busy_q <= |pend_nxt;
          end
        end
        ST_GATE: begin
          icg_q[active_q] <= 1'b0;
          cnt_q           <= CNT_W'(GATE_CYC - 1);
          state_q         <= ST_WAIT_G;
        end
        ST_WAIT_G: begin
          if (cnt_q == '0) state_q <= ST_APPLY;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_APPLY: begin
          div_q[int'(active_q)*DIV_DW +: DIV_DW] <= snap_div_q;
          tog_q[active_q]  <= snap_tog_q;
          cken_q[active_q] <= snap_cken_q;
          cnt_q            <= CNT_W'(SETTLE_CYC - 1);
          state_q          <= ST_WAIT_S;
        end
        ST_WAIT_S: begin
          if (cnt_q == '0) state_q <= ST_UNGATE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_UNGATE: begin
          icg_q[active_q] <= shd_icg[active_q];
          state_q         <= ST_IDLE;
          busy_q          <= |pend_nxt;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pready       = 1'b1;
  assign reg_clk_div  = div_q;
  assign reg_clk_tog  = tog_q;
  assign reg_clk_cken = cken_q;
  assign reg_icg_on   = icg_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ma_clk_cfg_seq.sv
// Directed bench for ma_clk_cfg_seq: APB read data checked through an expected
// queue, divider application events checked in order by a monitor queue.
module tb_ma_clk_cfg_seq;

  localparam int DIV_DW     = 4;
  localparam int GATE_CYC   = 32;
  localparam int SETTLE_CYC = 32;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT_G = 3'd2;

  logic        clk, src_rst, psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, busy;
  logic [19:0] reg_clk_div;
  logic [4:0]  reg_clk_tog, reg_clk_cken, reg_icg_on;
  logic [2:0]  dbg_state;
  logic        err;

  logic [31:0] exp_q[$];
  logic [31:0] apply_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  ma_clk_cfg_seq #(
    .DIV_DW(DIV_DW), .GATE_CYC(GATE_CYC), .SETTLE_CYC(SETTLE_CYC), .RST_DIV(1)
  ) dut (
    .src_clk(clk), .src_rst(src_rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .reg_clk_div(reg_clk_div), .reg_clk_tog(reg_clk_tog), .reg_clk_cken(reg_clk_cken),
    .reg_icg_on(reg_icg_on), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev(input int d, input logic [3:0] dv);
    return (32'(d) << 8) | 32'(dv);
  endfunction

  // Driver tasks
  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic e);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1 e = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input string tag, input logic [4:0] a, input logic [31:0] exp_d,
                          input logic exp_err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    exp_q.push_back(exp_d);
    @(negedge clk);
    penable = 1'b1;
    #1;
    chk({tag, "_rdata"}, prdata, exp_q.pop_front());
    chk({tag, "_slverr"}, 32'(pslverr), 32'(exp_err));
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int k;
    k = 0;
    while ((busy === 1'b1) && (k < max_cyc)) begin
      @(posedge clk);
      #1;
      k++;
      chk({tag, "_gate_overlap"}, 32'($countones(~reg_icg_on) <= 1), 32'd1);
    end
    chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: every divider slice change must match the next queued event.
  initial begin
    logic [19:0] prev;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (src_rst === 1'b0) begin
        for (int d = 0; d < 5; d++) begin
          if (reg_clk_div[d*4 +: 4] !== prev[d*4 +: 4]) begin
            if (apply_q.size() == 0)
              chk("apply_unexpected", ev(d, reg_clk_div[d*4 +: 4]), 32'hDEAD);
            else
              chk("apply_order", ev(d, reg_clk_div[d*4 +: 4]), apply_q.pop_front());
          end
        end
      end
      prev = reg_clk_div;
    end
  end

  // Directed sequence
  initial begin
    src_rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    err = 1'b0;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_div", 32'(reg_clk_div), 32'h11111);
    chk("rst_tog", 32'(reg_clk_tog), 32'h0);
    chk("rst_cken", 32'(reg_clk_cken), 32'h1F);
    chk("rst_icg", 32'(reg_icg_on), 32'h1F);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_prdata_idle", prdata, 32'h0);
    chk("rst_pready", 32'(pready), 32'h1);
    @(negedge clk);
    src_rst = 1'b0;
    apb_read("rst_status", 5'h14, 32'h0, 1'b0);
    apb_read("rst_cfg0", 5'h00, 32'h601, 1'b0);

    // 2: single-domain sequence timing
    apb_write(5'h04, 32'h603, err);
    apply_q.push_back(ev(1, 4'h3));
    chk("t2_err", 32'(err), 32'h0);
    chk("t2_busy_T", 32'(busy), 32'h1);
    wait_edges(1);
    chk("t2_icg_T1", 32'(reg_icg_on), 32'h1F);
    wait_edges(1);
    chk("t2_icg_T2", 32'(reg_icg_on), 32'h1D);
    wait_edges(32);
    chk("t2_div_T34", 32'(reg_clk_div), 32'h11111);
    wait_edges(1);
    chk("t2_div_T35", 32'(reg_clk_div), 32'h11131);
    wait_edges(32);
    chk("t2_icg_T67", 32'(reg_icg_on), 32'h1D);
    wait_edges(1);
    chk("t2_icg_T68", 32'(reg_icg_on), 32'h1F);
    chk("t2_busy_T68", 32'(busy), 32'h0);
    chk("t2_state_T68", 32'(dbg_state), 32'(S_IDLE));

    // 3: IMP and CPU queued behind an I2C sequence; CPU must go first
    apb_write(5'h0C, 32'h609, err);
    apply_q.push_back(ev(3, 4'h9));
    apb_write(5'h10, 32'h60A, err);
    apb_write(5'h00, 32'h60C, err);
    apply_q.push_back(ev(0, 4'hC));
    apply_q.push_back(ev(4, 4'hA));
    wait_idle("t3", 400);
    chk("t3_div", 32'(reg_clk_div), 32'hA913C);
    chk("t3_cken", 32'(reg_clk_cken), 32'h1F);
    chk("t3_icg", 32'(reg_icg_on), 32'h1F);
    chk("t3_apply_drained", 32'(apply_q.size()), 32'h0);

    // 4: ICG-only write takes effect next cycle with no sequence
    apb_write(5'h08, 32'h201, err);
    chk("t4_busy_T", 32'(busy), 32'h0);
    wait_edges(1);
    chk("t4_icg_T1", 32'(reg_icg_on), 32'h1B);
    chk("t4_busy_T1", 32'(busy), 32'h0);
    apb_read("t4_cfg2", 5'h08, 32'h201, 1'b0);

    // 5: reset in the middle of WAIT_G
    @(negedge clk);
    src_rst = 1'b1;
    @(negedge clk);
    src_rst = 1'b0;
    apb_write(5'h00, 32'h605, err);
    wait_edges(10);
    chk("t5_state_waitg", 32'(dbg_state), 32'(S_WAIT_G));
    chk("t5_icg_gated", 32'(reg_icg_on), 32'h1E);
    @(negedge clk);
    src_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_div", 32'(reg_clk_div), 32'h11111);
    chk("t5_tog", 32'(reg_clk_tog), 32'h0);
    chk("t5_cken", 32'(reg_clk_cken), 32'h1F);
    chk("t5_icg", 32'(reg_icg_on), 32'h1F);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    src_rst = 1'b0;
    wait_edges(80);
    chk("t5_div_after", 32'(reg_clk_div), 32'h11111);
    chk("t5_busy_after", 32'(busy), 32'h0);
    apb_read("t5_status", 5'h14, 32'h0, 1'b0);
    apb_read("t5_cfg0", 5'h00, 32'h601, 1'b0);

    // 6: invalid addresses, STATUS write, rewrite during WAIT_S
    apb_write(5'h18, 32'h605, err);
    chk("t6_wr18_err", 32'(err), 32'h1);
    wait_edges(2);
    chk("t6_wr18_div", 32'(reg_clk_div), 32'h11111);
    chk("t6_wr18_busy", 32'(busy), 32'h0);
    apb_read("t6_rd18", 5'h18, 32'h0, 1'b1);
    apb_read("t6_rd1c", 5'h1C, 32'h0, 1'b1);
    apb_write(5'h14, 32'hFFFF_FFFF, err);
    chk("t6_wrstatus_err", 32'(err), 32'h0);
    apb_read("t6_status_ro", 5'h14, 32'h0, 1'b0);
    apb_write(5'h0C, 32'h605, err);
    apply_q.push_back(ev(3, 4'h5));
    wait_edges(39);
    apb_read("t6_status_waits", 5'h14, 32'hC1, 1'b0);
    apb_write(5'h0C, 32'h607, err);
    apply_q.push_back(ev(3, 4'h7));
    apb_read("t6_status_pend", 5'h14, 32'hD1, 1'b0);
    wait_idle("t6", 400);
    chk("t6_div_final", 32'(reg_clk_div), 32'h17111);
    chk("t6_icg_final", 32'(reg_icg_on), 32'h1F);
    chk("t6_apply_drained", 32'(apply_q.size()), 32'h0);
    apb_read("t6_cfg3", 5'h0C, 32'h607, 1'b0);

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
